cam_capture_ctrl: RTL
=====================

// Module: cam_capture_ctrl
// PURPOSE
//  Frame-capture sequencer for the camera write path, in the PCLK domain. Arms on a request
//  from the AHB side and frames on VSYNC/HREF. Pairs bytes into 16-bit pixels and drives the
//  write strobe/address for RAM port A. Checks frame geometry and reports done/error back to
//  the bus-side status logic.
// PARAMETERS
//  ADDR_W   17   RAM port-A word address width
//  H_PIX    320  pixels per line (2 bytes each)
//  V_LINES  240  lines per frame
// PORTS
//  PCLK        in   1       pixel clock, posedge
//  HRESETn     in   1       reset, asynchronous, active-low
//  cap_req     in   1       capture request level (HCLK domain); 2-flop synced to req_s
//  cap_cont    in   1       0 = single frame, 1 = continuous (quasi-static)
//  VSYNC       in   1       camera vsync, high = vertical blanking
//  HREF        in   1       camera line-valid
//  byte_hi     out  1       1: current byte -> data[15:8], 0: -> data[7:0] (combinational)
//  pix_we      out  1       RAM port-A write strobe (registered)
//  pix_addr    out  ADDR_W  RAM port-A word address (registered)
//  frame_done  out  1       level: a complete frame is in RAM
//  frame_err   out  1       sticky per frame: geometry mismatch or overflow
//  busy        out  1       state != IDLE
//  frame_cnt   out  16      good-frame counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; byte_hi=1; counters 0; req_s 0.
//  FSM (PCLK):
//   IDLE : req_s -> ARM.
//   ARM  : VSYNC=1 -> SOF.
//   SOF  : VSYNC=0 -> CAP. pix_addr, line/byte counters and frame_err clear on entry.
//   CAP  : VSYNC=1 -> DONE. On exit frame_err |= (line_cnt!=V_LINES).
//   DONE : frame_done=1. ~req_s -> IDLE. cap_cont & req_s -> SOF
//          (VSYNC already high); frame_done drops on SOF entry.
//   ~req_s in ARM/SOF/CAP -> IDLE (abort). frame_done stays 0, frame_err cleared.
//  Byte pairing, CAP only, while HREF=1:
//   - phase toggles every PCLK; first byte phase 0 (byte_hi=1), second phase 1 (byte_hi=0).
//   - phase forced 0 whenever HREF=0 or state!=CAP.
//  Write:
//   - pix_we=1 for exactly one PCLK, the cycle after a phase-1 byte is sampled.
//   - pix_addr holds the pixel index during that cycle, then increments by 1.
//  Line check on HREF fall in CAP:
//   - byte count != 2*H_PIX -> frame_err=1; line_cnt++.
//   - odd byte count: trailing byte is dropped, no write.
//  Overflow:
//   - a write at pix_addr = H_PIX*V_LINES-1 is the last; further pix_we suppressed.
//   - any further phase-1 byte sets frame_err.
//   - pix_addr never wraps.
//  HREF high when VSYNC rises: line truncated, no write of the partial pair; line check still applies.
//  frame_err persists through DONE; cleared on SOF entry or abort.
//  Mid-operation reset: immediate return to reset values; no pix_we after HRESETn falls.
// CONFIGURATION
//  CAM_CTRL_FRAME_CNT_EN defined:
//   - frame_cnt increments (wraps at 16'hFFFF) on each CAP->DONE with frame_err=0.
//   - clears only on reset.
//  Undefined: frame_cnt tied 16'h0000, no counter logic.
// TESTING (H_PIX=4, V_LINES=3)
//  - Single frame: req=1, VSYNC pulse, 3 lines x 8 bytes, VSYNC high -> 12 pix_we, addr 0..11,
//    frame_done=1, frame_err=0; req=0 -> IDLE, frame_done=0.
//  - Short line: line 2 has 6 bytes -> 11 writes, frame_err=1, frame_done=1;
//    frame_cnt unchanged with _EN.
//  - Overflow: 4 good lines -> writes stop after addr 11, frame_err=1, pix_addr stays 12.
//  - Abort: req=0 mid line 2 -> IDLE next synced cycle, no further pix_we,
//    frame_done=0, frame_err=0.
//  - Continuous: cap_cont=1, two good frames -> addr restarts at 0 for frame 2;
//    frame_done low during frame 2; frame_cnt=2 with _EN, 0 without.
//  - Reset in CAP after 5 writes -> all outputs 0 immediately; next request restarts at addr 0.

Source files
------------

// File: rtl/cam_capture_if.sv
// Camera capture handshake bundle: request/sync inputs toward the sequencer, RAM-write and status outputs back.
interface cam_capture_if #(parameter int ADDR_W = 17);
   logic              cap_req;
   logic              cap_cont;
   logic              VSYNC;
   logic              HREF;
   logic              byte_hi;
   logic              pix_we;
   logic [ADDR_W-1:0] pix_addr;
   logic              frame_done;
   logic              frame_err;
   logic              busy;
   logic [15:0]       frame_cnt;

   modport master (
      output cap_req, cap_cont, VSYNC, HREF,
      input  byte_hi, pix_we, pix_addr, frame_done, frame_err, busy, frame_cnt
   );

   modport slave (
      input  cap_req, cap_cont, VSYNC, HREF,
      output byte_hi, pix_we, pix_addr, frame_done, frame_err, busy, frame_cnt
   );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: pairs camera bytes into 16-bit pixels and writes RAM port A.
// Optional good-frame counter enabled by defining CAM_CTRL_FRAME_CNT_EN.
module cam_capture_ctrl #(
   parameter int ADDR_W  = 17,
   parameter int H_PIX   = 320,
   parameter int V_LINES = 240
) (
   input logic          PCLK,
   input logic          HRESETn,
   cam_capture_if.slave cam
);
   // state | meaning
   // IDLE  | waiting for synced request
   // ARM   | waiting for VSYNC high (blanking)
   // SOF   | blanking, counters cleared, waiting for VSYNC low
   // CAP   | capturing lines
   // DONE  | frame complete, frame_done high
   typedef enum logic [2:0] {S_IDLE, S_ARM, S_SOF, S_CAP, S_DONE} state_t;

   localparam int BC_W = $clog2(2*H_PIX + 2);
   localparam int LC_W = $clog2(V_LINES + 2);
   localparam logic [BC_W-1:0]   BYTES_EXP = BC_W'(2*H_PIX);
   localparam logic [LC_W-1:0]   LINES_EXP = LC_W'(V_LINES);
   localparam logic [ADDR_W-1:0] PIX_END   = ADDR_W'(H_PIX*V_LINES);

   state_t            r_state;
   logic              r_req_s1, r_req_s;
   logic              r_phase;
   logic              r_pix_we;
   logic [ADDR_W-1:0] r_pix_addr;
   logic [BC_W-1:0]   r_byte_cnt;
   logic [LC_W-1:0]   r_line_cnt;
   logic              r_frame_done, r_frame_err, r_busy;

   logic              w_byte, w_full, w_line_end, w_err_acc;
   logic [LC_W-1:0]   w_lines_next;

   // A byte is taken only while capturing and before VSYNC truncates the line.
   assign w_byte       = (r_state == S_CAP) && r_req_s && cam.HREF && !cam.VSYNC;
   assign w_full       = (r_pix_addr == PIX_END);
   assign w_line_end   = (r_state == S_CAP) && (r_byte_cnt != '0) && (!cam.HREF || cam.VSYNC);
   assign w_lines_next = (w_line_end && !(&r_line_cnt)) ? r_line_cnt + 1'b1 : r_line_cnt;
   assign w_err_acc    = r_frame_err
                       | (w_line_end && (r_byte_cnt != BYTES_EXP))
                       | (w_byte && r_phase && w_full);

   always_ff @(posedge PCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state      <= S_IDLE;
         r_req_s1     <= 1'b0;
         r_req_s      <= 1'b0;
         r_phase      <= 1'b0;
         r_pix_we     <= 1'b0;
         r_pix_addr   <= '0;
         r_byte_cnt   <= '0;
         r_line_cnt   <= '0;
         r_frame_done <= 1'b0;
         r_frame_err  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_req_s1 <= cam.cap_req;
         r_req_s  <= r_req_s1;
         r_pix_we <= 1'b0;
         r_phase  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_req_s) begin
                  r_state <= S_ARM;
                  r_busy  <= 1'b1;
               end
            end
            S_ARM, S_SOF: begin
               if (!r_req_s) begin
                  r_state     <= S_IDLE;
                  r_busy      <= 1'b0;
                  r_frame_err <= 1'b0;
               end else if (r_state == S_ARM && cam.VSYNC) begin
                  r_state     <= S_SOF;
                  r_pix_addr  <= '0;
                  r_byte_cnt  <= '0;
                  r_line_cnt  <= '0;
                  r_frame_err <= 1'b0;
               end else if (r_state == S_SOF && !cam.VSYNC) begin
                  r_state <= S_CAP;
               end
            end
            S_CAP: begin
               if (!r_req_s) begin
                  r_state     <= S_IDLE;
                  r_busy      <= 1'b0;
                  r_frame_err <= 1'b0;
               end else begin
                  r_phase  <= w_byte & ~r_phase;
                  r_pix_we <= w_byte & r_phase & ~w_full;
                  if (r_pix_we) r_pix_addr <= r_pix_addr + 1'b1;
                  if (w_byte)
                     r_byte_cnt <= (&r_byte_cnt) ? r_byte_cnt : r_byte_cnt + 1'b1;
                  else if (!cam.HREF)
                     r_byte_cnt <= '0;
                  r_line_cnt <= w_lines_next;
                  if (cam.VSYNC) begin
                     r_state      <= S_DONE;
                     r_frame_done <= 1'b1;
                     r_frame_err  <= w_err_acc | (w_lines_next != LINES_EXP);
                  end else begin
                     r_frame_err <= w_err_acc;
                  end
               end
            end
            S_DONE: begin
               if (!r_req_s) begin
                  r_state      <= S_IDLE;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b0;
               end else if (cam.cap_cont) begin
                  r_state      <= S_SOF;
                  r_frame_done <= 1'b0;
                  r_pix_addr   <= '0;
                  r_byte_cnt   <= '0;
                  r_line_cnt   <= '0;
                  r_frame_err  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef CAM_CTRL_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   always_ff @(posedge PCLK or negedge HRESETn) begin
      if (!HRESETn)
         r_frame_cnt <= '0;
      else if (r_state == S_CAP && r_req_s && cam.VSYNC
               && !(w_err_acc || (w_lines_next != LINES_EXP)))
         r_frame_cnt <= r_frame_cnt + 16'd1;
   end

   assign cam.frame_cnt = r_frame_cnt;
`else
   assign cam.frame_cnt = 16'h0000;
`endif

   assign cam.byte_hi    = ~(w_byte & r_phase);
   assign cam.pix_we     = r_pix_we;
   assign cam.pix_addr   = r_pix_addr;
   assign cam.frame_done = r_frame_done;
   assign cam.frame_err  = r_frame_err;
   assign cam.busy       = r_busy;
endmodule
